bbc_micro_ram_arbiter: RTL
==========================

Name: bbc_micro_ram_arbiter

Overview:
- Shares the single synchronous RAM port between three requesters: 2MHz video fetch, CPU, and a host/debug port.
- Slots are scheduled from the clock_control enables produced by the micro clocking block.
- Video owns fixed slots, the CPU is serviced once per CPU cycle during phi2, and the host uses the remaining cycles.
- The block also flags CPU cycles whose data was not ready at the CPU clock enable.

Parameters:
- ADDR_WIDTH, 16, RAM and requester address width.
- DATA_WIDTH, 8, RAM data width.

Ports:
- clk  input  1  system clock, same clock as the clocking block.
- reset  input  1  synchronous, active-high reset.
- clock_control__will_enable_2MHz_video  input  1  next cycle is a video enable; marks the video slot.
- clock_control__enable_cpu  input  1  CPU clock enable; CPU samples read data this cycle.
- clock_control__phi  input  2  01 = phi1, 10 = phi2.
- video_req_valid  input  1  video fetch pending.
- video_address  input  ADDR_WIDTH  video fetch address.
- video_read_data  output  DATA_WIDTH  video fetch data.
- video_read_data_valid  output  1  one-cycle pulse with video_read_data.
- cpu_req_valid  input  1  CPU access requested for the current CPU cycle.
- cpu_read_not_write  input  1  1 = read.
- cpu_address  input  ADDR_WIDTH  CPU address.
- cpu_write_data  input  DATA_WIDTH  CPU write data.
- cpu_read_data  output  DATA_WIDTH  CPU read data, held until the next CPU read returns.
- cpu_data_ready  output  1  CPU access for this cycle has completed.
- cpu_miss  output  1  one-cycle pulse on a missed CPU access.
- cpu_miss_count  output  8  saturating count of cpu_miss pulses.
- host_req_valid  input  1  host request; held until acknowledged.
- host_read_not_write  input  1  1 = read.
- host_address  input  ADDR_WIDTH  host address.
- host_write_data  input  DATA_WIDTH  host write data.
- host_ack  output  1  one-cycle pulse when the host access is issued to RAM.
- host_read_data  output  DATA_WIDTH  host read data, held until the next host read returns.
- host_read_data_valid  output  1  one-cycle pulse, the cycle after the host_ack of a read.
- ram_select  output  1  RAM access this cycle.
- ram_read_not_write  output  1  1 = read.
- ram_address  output  ADDR_WIDTH  RAM address.
- ram_write_data  output  DATA_WIDTH  RAM write data.
- ram_read_data  input  DATA_WIDTH  RAM read data, valid one cycle after a read select.

Behaviour:
- One registered grant per cycle. Grant state is IDLE, VIDEO, CPU or HOST; the previous grant (last_grant) routes ram_read_data to the owning requester.
- RAM outputs are combinational from the current-cycle grant.
- Priority in each cycle:
  - VIDEO if will_enable_2MHz_video and video_req_valid.
  - Else CPU if phi == 10, cpu_req_valid and cpu_done == 0.
  - Else HOST if host_req_valid.
  - Else IDLE with ram_select = 0.
- A video slot with no video_req_valid is free for the CPU or host.
- Video is always a read. video_read_data_valid pulses the cycle after the VIDEO grant, coincident with enable_2MHz_video.
- cpu_done:
  - Set on the cycle after a CPU grant; cpu_data_ready = cpu_done.
  - Cleared on enable_cpu.
  - On a CPU read, cpu_read_data loads from ram_read_data at the same time cpu_done is set.
- CPU grant in the same cycle as enable_cpu:
  - The access still issues.
  - The clear caused by enable_cpu has priority over the set, so cpu_done = 0 afterwards.
  - A miss is flagged because data was not ready.
- cpu_miss pulses the cycle after enable_cpu when, at enable_cpu, cpu_req_valid = 1 and cpu_done = 0.
- cpu_miss_count increments on each cpu_miss and saturates at 0xFF.
- CPU requests during phi1 are never granted.
- host_ack pulses in the HOST grant cycle.
  - The host must deassert host_req_valid, or present a new request, the cycle after host_ack.
  - Host writes complete at ack.
- Reset values:
  - Grant state and last_grant IDLE; cpu_done 0; cpu_miss_count 0.
  - All valid, ack, miss and select outputs 0.
  - Read data registers 0.
- Reset mid-access: the in-flight read's data is discarded and no valid pulse follows. Reset has priority over all events.

Test Plan:
- Video slot with video_req_valid and cpu_req_valid in phi2 at address 0x3000 (RAM returns 0x5A) -> video granted; video_read_data = 0x5A with valid one cycle later; CPU granted the next cycle.
- CPU read of 0x1234 in phi2 (RAM returns 0xA5), enable_cpu 3 cycles later -> cpu_data_ready = 1 before enable_cpu; cpu_read_data = 0xA5; cleared after enable_cpu; no cpu_miss.
- CPU request granted in the same cycle as enable_cpu -> cpu_miss pulse; cpu_miss_count 0 -> 1. Repeat 300 times -> count holds at 0xFF.
- Host write 0x77 to 0x0100, then host read of 0x0100 with no video or CPU traffic -> host_ack on the first idle cycles; host_read_data = 0x77 one cycle after the read ack.
- Host request continuous while video and CPU saturate slots -> host_ack only in cycles with no video or CPU grant; never two RAM selects in one cycle.
- Reset asserted the cycle after a CPU read grant -> no cpu_data_ready; all outputs at reset values the next cycle.

Source files
------------

// File: rtl/bbc_micro_ram_arbiter.sv
// Shares one synchronous RAM port between 2MHz video, CPU (once per phi2) and a host port.
// Read data returns one cycle after the grant and is steered by the previous cycle's grant.
module bbc_micro_ram_arbiter #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clock_control__will_enable_2MHz_video,
   input  logic                  clock_control__enable_cpu,
   input  logic [1:0]            clock_control__phi,
   input  logic                  video_req_valid,
   input  logic [ADDR_WIDTH-1:0] video_address,
   output logic [DATA_WIDTH-1:0] video_read_data,
   output logic                  video_read_data_valid,
   input  logic                  cpu_req_valid,
   input  logic                  cpu_read_not_write,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic [DATA_WIDTH-1:0] cpu_write_data,
   output logic [DATA_WIDTH-1:0] cpu_read_data,
   output logic                  cpu_data_ready,
   output logic                  cpu_miss,
   output logic [7:0]            cpu_miss_count,
   input  logic                  host_req_valid,
   input  logic                  host_read_not_write,
   input  logic [ADDR_WIDTH-1:0] host_address,
   input  logic [DATA_WIDTH-1:0] host_write_data,
   output logic                  host_ack,
   output logic [DATA_WIDTH-1:0] host_read_data,
   output logic                  host_read_data_valid,
   output logic                  ram_select,
   output logic                  ram_read_not_write,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_write_data,
   input  logic [DATA_WIDTH-1:0] ram_read_data
);

   typedef enum logic [1:0] {GrantIdle, GrantVideo, GrantCpu, GrantHost} grant_e;

   grant_e                grant;
   grant_e                last_grant_q;
   logic                  last_rnw_q;
   logic                  cpu_done_q;
   logic                  cpu_miss_q;
   logic [7:0]            cpu_miss_count_q;
   logic [DATA_WIDTH-1:0] video_rdata_q;
   logic [DATA_WIDTH-1:0] cpu_rdata_q;
   logic [DATA_WIDTH-1:0] host_rdata_q;
   logic                  phi2;
   logic                  miss_event;
   logic                  video_ret;
   logic                  cpu_ret;
   logic                  host_ret;

   assign phi2       = (clock_control__phi == 2'b10);
   assign miss_event = clock_control__enable_cpu & cpu_req_valid & ~cpu_done_q;

   always_comb begin
      grant = GrantIdle;
      if (reset) begin
         grant = GrantIdle;
      end else if (clock_control__will_enable_2MHz_video && video_req_valid) begin
         grant = GrantVideo;
      end else if (phi2 && cpu_req_valid && !cpu_done_q) begin
         grant = GrantCpu;
      end else if (host_req_valid) begin
         grant = GrantHost;
      end
   end

   always_comb begin
      ram_select         = 1'b0;
      ram_read_not_write = 1'b1;
      ram_address        = '0;
      ram_write_data     = '0;
      case (grant)
         GrantVideo: begin
            ram_select  = 1'b1;
            ram_address = video_address;
         end
         GrantCpu: begin
            ram_select         = 1'b1;
            ram_read_not_write = cpu_read_not_write;
            ram_address        = cpu_address;
            ram_write_data     = cpu_write_data;
         end
         GrantHost: begin
            ram_select         = 1'b1;
            ram_read_not_write = host_read_not_write;
            ram_address        = host_address;
            ram_write_data     = host_write_data;
         end
         default: ;
      endcase
   end

   // Returns are suppressed while reset is high so an in-flight read is discarded.
   assign video_ret = ~reset & (last_grant_q == GrantVideo);
   assign cpu_ret   = ~reset & (last_grant_q == GrantCpu) & last_rnw_q;
   assign host_ret  = ~reset & (last_grant_q == GrantHost) & last_rnw_q;

   assign video_read_data       = video_ret ? ram_read_data : video_rdata_q;
   assign video_read_data_valid = video_ret;
   assign cpu_read_data         = cpu_ret ? ram_read_data : cpu_rdata_q;
   assign cpu_data_ready        = cpu_done_q & ~reset;
   assign cpu_miss              = cpu_miss_q & ~reset;
   assign cpu_miss_count        = cpu_miss_count_q;
   assign host_ack              = (grant == GrantHost);
   assign host_read_data        = host_ret ? ram_read_data : host_rdata_q;
   assign host_read_data_valid  = host_ret;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q     <= GrantIdle;
         last_rnw_q       <= 1'b0;
         cpu_done_q       <= 1'b0;
         cpu_miss_q       <= 1'b0;
         cpu_miss_count_q <= 8'h00;
         video_rdata_q    <= '0;
         cpu_rdata_q      <= '0;
         host_rdata_q     <= '0;
      end else begin
         last_grant_q <= grant;
         last_rnw_q   <= ram_read_not_write;
         if (video_ret) video_rdata_q <= ram_read_data;
         if (cpu_ret)   cpu_rdata_q   <= ram_read_data;
         if (host_ret)  host_rdata_q  <= ram_read_data;
         // A CPU clock enable in the grant cycle wins over the completion.
         if (clock_control__enable_cpu) begin
            cpu_done_q <= 1'b0;
         end else if (grant == GrantCpu) begin
            cpu_done_q <= 1'b1;
         end
         cpu_miss_q <= miss_event;
         if (miss_event && cpu_miss_count_q != 8'hFF) begin
            cpu_miss_count_q <= cpu_miss_count_q + 8'd1;
         end
      end
   end

endmodule
